// File: rtl/jk_bank_pkg.sv
// Shared constants for the JK bank arbiter: command encodings and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jk_bank_pkg;

    // JK command encodings ({J,K} applied to every masked bit)
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    // Arbiter FSM: IDLE picks a winner, EXEC drives the bank for one cycle
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/jk_bit_cell.sv
// One JK flip-flop bit of the shared bank, with complementary outputs.
// Latency: q updates on the rising edge after j/k are presented.
// Backpressure: none; j=k=0 holds the bit.
module jk_bit_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    // JK update rule: hold, clear, set, toggle; synchronous reset to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one bank of JK flip-flops between NREQ requesters.
// Latency: req sampled at E0 -> gnt high E0..E1 -> Q updated at E1; one command per 2 cycles.
// Backpressure: requesters hold req until they see gnt; ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
import jk_bank_pkg::*;

module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   mask,
    output logic [NREQ-1:0]         gnt,
    output logic [IDW-1:0]          gnt_id,
    output logic                    busy,
    output logic [WIDTH-1:0]        Q,
    output logic [WIDTH-1:0]        Q_bar
);

    state_t             state;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   mask_r;
    logic [IDW-1:0]     search_base;
    logic [IDW-1:0]     win;
    logic [1:0]         win_op;
    logic [WIDTH-1:0]   win_mask;
    logic [IDW-1:0]     next_ptr;
    logic               exec;
    logic [WIDTH-1:0]   j_vec;
    logic [WIDTH-1:0]   k_vec;

    // First requester with req set, scanning upward from base with wrap-around.
    // With fixed priority the base is tied to 0, so the lowest index always wins.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  base);
        logic [IDW-1:0] w;
        logic           found;
        int             idx;
        w     = '0;
        found = 1'b0;
        for (int n = 0; n < NREQ; n++) begin
            idx = (int'(base) + n) % NREQ;
            if (!found && r[idx]) begin
                w     = IDW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

`ifdef ARB_FIXED_PRIO_EN
    // No rotation state: every search starts at requester 0
    assign search_base = '0;
`else
    logic [IDW-1:0] rr_ptr;

    // Rotate the search start past the requester just served
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == ST_EXEC) begin
            rr_ptr <= next_ptr;
        end
    end

    assign search_base = rr_ptr;
`endif

    // The requester after the one served, wrapping NREQ-1 back to 0
    assign next_ptr = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

    assign win = rr_pick(req, search_base);

    // Extract the winner's command and mask from the packed request buses
    always_comb begin
        win_op   = OP_HOLD;
        win_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_op   = op[2*i +: 2];
                win_mask = mask[WIDTH*i +: WIDTH];
            end
        end
    end

    // Two-state grant FSM: latch the winner's command, then execute it for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_r   <= OP_HOLD;
            mask_r <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        op_r   <= win_op;
                        mask_r <= win_mask;
                        gnt    <= NREQ'(1) << win;
                        gnt_id <= win;
                        busy   <= 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bank inputs are non-zero only during EXEC and only on masked bits
    assign exec  = (state == ST_EXEC);
    assign j_vec = mask_r & {WIDTH{exec & op_r[1]}};
    assign k_vec = mask_r & {WIDTH{exec & op_r[0]}};

    // The shared JK bank itself
    genvar b;
    generate
        for (b = 0; b < WIDTH; b++) begin : g_bank
            jk_bit_cell u_cell (
                .clk   (clk),
                .rst   (rst),
                .j     (j_vec[b]),
                .k     (k_vec[b]),
                .q     (Q[b]),
                .q_bar (Q_bar[b])
            );
        end
    endgenerate

endmodule
